// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// mux_arb_pkg : shared types and constants for the mux4_1 select arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Channel index successor; the 2-bit width gives the 3 -> 0 wrap for free.
  function automatic sel_t sel_inc(input sel_t s);
    return s + sel_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// rr_pick4 : combinational 4-way round-robin picker (first req at/after ptr)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] pick,
  output logic [3:0] onehot
);

  logic found;
  sel_t idx;

  always_comb begin
    any   = |req;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    onehot = any ? (4'b0001 << pick) : 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_rr_arbiter : round-robin select generator with registered valid/ready
//                  output stage. Optional MUX_ARB_LOCK_EN adds lock[3:0].
// Revision       : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int WIDTH  = 1,
  parameter int NUM_CH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
`ifdef MUX_ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  import mux_arb_pkg::*;

  if (NUM_CH != mux_arb_pkg::NUM_CH) begin : g_bad_num_ch
    $error("mux_rr_arbiter: NUM_CH must be 4");
  end

  state_t           state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             pick_any;
  sel_t             pick_idx;
  logic [3:0]       pick_onehot;
  logic [WIDTH-1:0] pick_data;
  logic             load;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .pick   (pick_idx),
    .onehot (pick_onehot)
  );

  // Only the picked (hence requesting) channel reaches the register, so
  // X on idle channels never lands in out_data.
  always_comb begin
    pick_data = in1;
    case (pick_idx)
      2'd0:    pick_data = in1;
      2'd1:    pick_data = in2;
      2'd2:    pick_data = in3;
      default: pick_data = in4;
    endcase
  end

  always_comb begin
    load       = pick_any && ((state_q == EMPTY) || out_ready) && !rst;
    gnt        = load ? pick_onehot : 4'b0000;
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_sel_d  = out_sel_q;
    out_data_d = out_data_q;

    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (load)           state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (load) begin
      out_sel_d  = pick_idx;
      out_data_d = pick_data;
`ifdef MUX_ARB_LOCK_EN
      // A locked grant parks the pointer on the winner for burst priority.
      ptr_d      = lock[pick_idx] ? pick_idx : sel_inc(pick_idx);
`else
      ptr_d      = sel_inc(pick_idx);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      out_sel_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_arbiter : directed self-checking bench for mux_rr_arbiter/rr_pick4
// Revision          : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [0:0] in1, in2, in3, in4;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] out_data;
  logic [1:0] out_sel;
`ifdef MUX_ARB_LOCK_EN
  logic [3:0] lock;
`endif

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic       pk_any;
  logic [1:0] pk_pick;
  logic [3:0] pk_onehot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(1), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  rr_pick4 u_pick_ut (
    .req    (pk_req),
    .ptr    (pk_ptr),
    .any    (pk_any),
    .pick   (pk_pick),
    .onehot (pk_onehot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b0; in4 = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    in1 = 1'b1; in2 = 1'b1; in3 = 1'b1; in4 = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
    checks++; if (out_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", out_data); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b1; in4 = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
      tick();
      checks++; if (out_sel !== 2'(i % 4)) begin errors++; $display("FAIL rot_sel[%0d]: got %0d want %0d", i, out_sel, i % 4); end
      checks++; if (out_data !== ((i % 4) == 2 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rot_data[%0d]: got %b", i, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d]: got %b want 1", i, out_valid); end
    end
    req = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rot_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in3 = 1'b1;
    req = 4'b0100; out_ready = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_gnt: got %b want 0100", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2) begin errors++; $display("FAIL bp_load: got v=%b s=%0d want v=1 s=2", out_valid, out_sel); end
    for (int i = 0; i < 3; i++) begin
      req = 4'b0100; in3 = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_stall_gnt[%0d]: got %b want 0000", i, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%b want v=1 s=2 d=1", i, out_valid, out_sel, out_data);
      end
    end
    req = 4'b0000; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_pre: got %b want 0100", gnt); end
    tick();
    req = 4'b0011;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
    tick();
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel0: got %0d want 0", out_sel); end
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1: got %b want 0010", gnt); end
    tick();
    checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL wrap_sel1: got %0d want 1", out_sel); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in1 = 1'b1; req = 4'b0001; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %b want 1", out_valid); end
    req = 4'b0010; rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt: got %b want 0000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 1'b0) begin
      errors++; $display("FAIL rmid_clear: got v=%b s=%0d d=%b want 0 0 0", out_valid, out_sel, out_data);
    end
    rst = 1'b0; req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in1 = 1'b1; in2 = 1'bx; out_ready = 1'b1; req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0: got %b want 0001", gnt); end
    tick();
    checks++; if (out_data !== 1'b1 || out_sel !== 2'd0) begin errors++; $display("FAIL b2b_x_iso: got d=%b s=%0d want d=1 s=0", out_data, out_sel); end
    in1 = 1'b0; in2 = 1'b1; req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt1: got %b want 0010", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 1'b1) begin
      errors++; $display("FAIL b2b_replace: got v=%b s=%0d d=%b want 1 1 1", out_valid, out_sel, out_data);
    end
    req = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    out_ready = 1'b1; req = 4'b1010; lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_hold[%0d]: got %b want 0010", i, gnt); end
      tick();
    end
    lock = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_release: got %b want 0010", gnt); end
    tick();
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lock_next: got %b want 1000", gnt); end
    req = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_picker();
    logic       e_any;
    logic [1:0] e_pick;
    logic [3:0] e_oh;
    logic       found;
    int         idx;
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        pk_req = 4'(r); pk_ptr = 2'(p);
        #1;
        e_any = (r != 0); e_pick = 2'd0; e_oh = 4'b0000; found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          idx = (p + k) % 4;
          if (!found && pk_req[idx]) begin
            found = 1'b1; e_pick = 2'(idx); e_oh = 4'b0001 << idx;
          end
        end
        checks++;
        if (pk_any !== e_any || pk_pick !== e_pick || pk_onehot !== e_oh) begin
          errors++;
          $display("FAIL picker req=%b ptr=%0d: got any=%b pick=%0d oh=%b want any=%b pick=%0d oh=%b",
                   pk_req, pk_ptr, pk_any, pk_pick, pk_onehot, e_any, e_pick, e_oh);
        end
      end
    end
  endtask

  initial begin
    pk_req = 4'b0000; pk_ptr = 2'd0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_picker();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
